spi_irq_service_master: RTL
===========================

// Module: spi_irq_service_master
// PURPOSE
//  Avalon-MM master that services the SPI peripheral's level interrupt. On irq it
//  reads the status register for the pending word count, drains that many words
//  from the data register into an internal FIFO, then writes the IRQ return
//  register to clear the interrupt. Sits between the SPI block and the speech DSP
//  front end, which consumes words via a valid/ready stream.
// PARAMETERS
//  OFFSET      2'd0  register-bank select; forms address bits [4:3]
//  DATA_W      16    Avalon data / stream word width
//  FIFO_DEPTH  16    output FIFO depth; power of two, >= 2
//  MAX_BURST   8     max words drained per interrupt; status count clamped to this
// PORTS
//  clk                 in   1       system clock
//  rst                 in   1       synchronous, active-high reset
//  irq                 in   1       level interrupt from the SPI slave IRQ register
//  avm_m0_address      out  16      word address
//  avm_m0_read         out  1       read strobe
//  avm_m0_write        out  1       write strobe
//  avm_m0_writedata    out  DATA_W  write data (always 0; the write itself acks)
//  avm_m0_readdata     in   DATA_W  read data, valid when read && !waitrequest
//  avm_m0_waitrequest  in   1       slave stall
//  out_data            out  DATA_W  FIFO head word
//  out_valid           out  1       FIFO not empty
//  out_ready           in   1       consumer accepts out_data when valid && ready
//  busy                out  1       high in any state other than IDLE
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Addresses: ACK = {11'd0,OFFSET,3'h0}, STAT = {11'd0,OFFSET,3'h1},
//    DATA = {11'd0,OFFSET,3'h2}.
//  - Reset: read=0, write=0, address=0, writedata=0, FIFO empty (out_valid=0),
//    busy=0, state=IDLE. Reset mid-transaction drops strobes next edge; FIFO contents lost.
//  - Avalon rules: address/read/write registered; held stable while waitrequest=1;
//    transfer completes on the edge where strobe=1 && waitrequest=0; strobe
//    deasserts the following cycle. read and write never both high.
//  - FSM:
//    IDLE   : irq=1 -> STAT.
//    STAT   : read STAT; on completion cnt = min(readdata[7:0], MAX_BURST);
//             cnt=0 -> ACK, else -> DRAIN.
//    DRAIN  : if FIFO has a free slot, read DATA; on completion push readdata,
//             cnt--. Read is not issued while FIFO full (no overflow possible).
//             cnt reaches 0 -> ACK.
//    ACK    : write ACK; on completion -> GUARD.
//    GUARD  : one cycle, ignore irq (slave clears its flag on the ack edge) -> IDLE.
//  - An irq re-raised after the ack (the slave's set has priority over clear) is
//    seen in IDLE and serviced again; nothing is lost.
//  - FIFO: push and pop in the same cycle allowed when full or empty+push only as
//    counted; occupancy counter width clog2(FIFO_DEPTH)+1; pointers wrap modulo
//    depth. Push on full never occurs by construction.
//  - out_data is the registered FIFO head; first pushed word visible 1 cycle after push.
//  - Latency, zero waitstates, cnt=N: irq high -> STAT read 1 cycle later; ACK
//    write issued 2N+3 cycles after irq (read, deassert per transfer).
// TESTING
//  - irq=1, STAT=3, DATA returns 0x1111,0x2222,0x3333, out_ready=1 -> stream out in
//    order; exactly one write to ACK addr; busy low after GUARD.
//  - STAT=0 -> no DATA reads; single ACK write; FIFO stays empty.
//  - STAT=0x20 with MAX_BURST=8 -> exactly 8 DATA reads, then ACK.
//  - FIFO_DEPTH=4, out_ready=0, STAT=6 -> 4 reads, read strobe held low until
//    out_ready=1 frees slots; remaining 2 reads then ACK; all 6 words correct.
//  - waitrequest=1 for 3 cycles on each transfer -> address/strobe stable; each
//    transfer completes exactly once.
//  - rst asserted during DRAIN -> next edge read=0, out_valid=0, IDLE; irq still
//    high afterwards -> fresh STAT read.

Source files
------------

// File: rtl/spi_irq_service_master_if.sv
// Avalon-MM master port plus valid/ready output stream of the SPI IRQ service master.
// The design connects through the master modport and the bus/consumer side through the slave modport.
interface spi_irq_service_master_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       avm_m0_address;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic [DATA_W-1:0] avm_m0_writedata;
  logic [DATA_W-1:0] avm_m0_readdata;
  logic              avm_m0_waitrequest;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    input  avm_m0_readdata, avm_m0_waitrequest,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    output avm_m0_readdata, avm_m0_waitrequest,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/spi_irq_service_master.sv
// Services the SPI level interrupt: reads the pending count, drains that many data words
// into a small FIFO feeding the DSP stream, then writes the IRQ return register.
module spi_irq_service_master #(
  parameter logic [1:0] OFFSET     = 2'd0,
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_BURST  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic busy,
  spi_irq_service_master_if.master bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [15:0] ADDR_ACK  = {11'd0, OFFSET, 3'h0};
  localparam logic [15:0] ADDR_STAT = {11'd0, OFFSET, 3'h1};
  localparam logic [15:0] ADDR_DATA = {11'd0, OFFSET, 3'h2};

  typedef enum logic [2:0] {IDLE, STAT, DRAIN, ACK, GUARD} state_t;

  state_t             r_state, w_stateNext;
  logic               r_read, w_readNext;
  logic               r_write, w_writeNext;
  logic [15:0]        r_addr, w_addrNext;
  logic [BURST_W-1:0] r_cnt, w_cntNext;
  logic [BURST_W-1:0] w_clamped;
  logic               w_done, w_push, w_pop, w_full;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]   r_count;

  assign w_done = (r_read | r_write) & ~bus.avm_m0_waitrequest;
  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) & bus.out_ready;

  // Pending count from the status register, clamped so one interrupt never drains more than MAX_BURST words.
  always_comb begin
    w_clamped = BURST_W'(MAX_BURST);
    if (int'(bus.avm_m0_readdata[7:0]) <= MAX_BURST) begin
      w_clamped = BURST_W'(bus.avm_m0_readdata[7:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_read  <= w_readNext;
      r_write <= w_writeNext;
      r_addr  <= w_addrNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Strobes are computed one cycle ahead so they come out registered; a DATA read is only launched with a free FIFO slot.
  always_comb begin
    w_stateNext = r_state;
    w_readNext  = r_read;
    w_writeNext = r_write;
    w_addrNext  = r_addr;
    w_cntNext   = r_cnt;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (irq) begin
          w_stateNext = STAT;
          w_readNext  = 1'b1;
          w_addrNext  = ADDR_STAT;
        end
      end
      STAT: begin
        if (w_done) begin
          w_readNext  = 1'b0;
          w_cntNext   = w_clamped;
          w_stateNext = (w_clamped == '0) ? ACK : DRAIN;
        end
      end
      DRAIN: begin
        if (r_read) begin
          if (w_done) begin
            w_readNext = 1'b0;
            w_push     = 1'b1;
            w_cntNext  = r_cnt - BURST_W'(1);
            if (r_cnt == BURST_W'(1)) begin
              w_stateNext = ACK;
            end
          end
        end else if (!w_full) begin
          w_readNext = 1'b1;
          w_addrNext = ADDR_DATA;
        end
      end
      ACK: begin
        if (!r_write) begin
          w_writeNext = 1'b1;
          w_addrNext  = ADDR_ACK;
        end else if (w_done) begin
          w_writeNext = 1'b0;
          w_stateNext = GUARD;
        end
      end
      GUARD: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.avm_m0_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.avm_m0_address   = r_addr;
  assign bus.avm_m0_read      = r_read;
  assign bus.avm_m0_write     = r_write;
  assign bus.avm_m0_writedata = '0;
  assign bus.out_data         = r_mem[r_rdPtr];
  assign bus.out_valid        = (r_count != '0);
  assign busy                 = (r_state != IDLE);
endmodule
